decode_stage: RTL and testbench



---
 rtl/decode_pkg.sv | 123 ++++++++++++
 rtl/decode_stage_if.sv | 38 +++
 rtl/decode_stage_imm_gen.sv | 52 +++++
 rtl/decode_stage.sv | 110 +++++++++++
 tb/tb_decode_stage.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared types, encodings and the opcode decoder for the RV32-subset decode stage.
package decode_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned OP_W    = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_LW   = 4'd3,
        OP_SW   = 4'd4,
        OP_ADDI = 4'd5,
        OP_LUI  = 4'd6,
        OP_BEQ  = 4'd7,
        OP_JAL  = 4'd8,
        OP_ILL  = 4'd15
    } op_e;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_type_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    typedef struct packed {
        op_e              op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        imm_type_e        imm_type;
        logic             illegal;
    } dec_t;

    // Opcode classification plus the register fields and immediate format each op uses.
    function automatic dec_t decode(input logic [INSTR_W-1:0] instr);
        dec_t       d;
        logic [6:0] opcode;
        logic [2:0] f3;
        logic [6:0] f7;
        opcode     = instr[6:0];
        f3         = instr[14:12];
        f7         = instr[31:25];
        d.op       = OP_ILL;
        d.rd       = '0;
        d.rs1      = '0;
        d.rs2      = '0;
        d.imm_type = IMM_NONE;
        d.illegal  = 1'b0;

        case (opcode)
            OPC_OP: begin
                if (f3 == F3_ADD_SUB && f7 == F7_ADD) begin
                    d.op = OP_ADD;
                end else if (f3 == F3_ADD_SUB && f7 == F7_SUB) begin
                    d.op = OP_SUB;
                end
            end
            OPC_LOAD:   if (f3 == F3_LW)   d.op = OP_LW;
            OPC_STORE:  if (f3 == F3_SW)   d.op = OP_SW;
            OPC_OP_IMM: if (f3 == F3_ADDI) d.op = OP_ADDI;
            OPC_LUI:    d.op = OP_LUI;
            OPC_BRANCH: if (f3 == F3_BEQ)  d.op = OP_BEQ;
            OPC_JAL:    d.op = OP_JAL;
            default:    d.op = OP_ILL;
        endcase

        case (d.op)
            OP_ADD, OP_SUB: begin
                d.rd  = instr[11:7];
                d.rs1 = instr[19:15];
                d.rs2 = instr[24:20];
            end
            OP_LW, OP_ADDI: begin
                d.rd       = instr[11:7];
                d.rs1      = instr[19:15];
                d.imm_type = IMM_I;
            end
            OP_SW: begin
                d.rs1      = instr[19:15];
                d.rs2      = instr[24:20];
                d.imm_type = IMM_S;
            end
            OP_LUI: begin
                d.rd       = instr[11:7];
                d.imm_type = IMM_U;
            end
            OP_BEQ: begin
                d.rs1      = instr[19:15];
                d.rs2      = instr[24:20];
                d.imm_type = IMM_B;
            end
            OP_JAL: begin
                d.rd       = instr[11:7];
                d.imm_type = IMM_J;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) ();
    import decode_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    op_e              out_op;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [XLEN-1:0]  out_imm;
    logic [XLEN-1:0]  out_pc;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    // The decode stage itself.
    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_pc, out_illegal, illegal_cnt
    );

    // The surrounding pipeline: fetch drives, execute consumes.
    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_pc, out_illegal, illegal_cnt
    );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: picks the I/S/B/U/J field layout and extends it to XLEN.
module imm_gen
    import decode_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter bit          SIGN_EXT = 1'b1
) (
    input  logic [31:7]     instr,
    input  imm_type_e       imm_type,
    output logic [XLEN-1:0] imm_c
);

    logic        sgn;
    logic        ext;
    logic [31:0] raw;

    // Legacy mode clears the fill bit so every field is zero-extended.
    assign sgn = SIGN_EXT & instr[31];

    always_comb begin
        raw = '0;
        ext = 1'b0;
        case (imm_type)
            IMM_I: begin
                raw = {{20{sgn}}, instr[31:20]};
                ext = sgn;
            end
            IMM_S: begin
                raw = {{20{sgn}}, instr[31:25], instr[11:7]};
                ext = sgn;
            end
            IMM_B: begin
                raw = {{19{sgn}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                ext = sgn;
            end
            IMM_J: begin
                raw = {{11{sgn}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                ext = sgn;
            end
            IMM_U:   raw = {instr[31:12], 12'b0};
            default: raw = '0;
        endcase

        // U results never carry a sign above bit 31.
        if (ext) begin
            imm_c = XLEN'($signed(raw));
        end else begin
            imm_c = XLEN'(raw);
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32-subset decode stage: one-entry output buffer with back-pressure,
// flush, and a saturating count of accepted illegal instructions.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter bit          SIGN_EXT = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);

    dec_t             dec_c;
    logic [XLEN-1:0]  imm_c;
    logic             in_ready_c;
    logic             accept_c;

    logic             out_valid_q,   out_valid_d;
    op_e              op_q,          op_d;
    logic [4:0]       rd_q,          rd_d;
    logic [4:0]       rs1_q,         rs1_d;
    logic [4:0]       rs2_q,         rs2_d;
    logic [XLEN-1:0]  imm_q,         imm_d;
    logic [XLEN-1:0]  pc_q,          pc_d;
    logic             illegal_q,     illegal_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

    assign dec_c = decode(bus.in_instr);

    imm_gen #(
        .XLEN     (XLEN),
        .SIGN_EXT (SIGN_EXT)
    ) u_imm_gen (
        .instr    (bus.in_instr[31:7]),
        .imm_type (dec_c.imm_type),
        .imm_c    (imm_c)
    );

    // Accept when the buffer is empty or draining; flush blocks intake outright.
    assign in_ready_c = !bus.flush && (!out_valid_q || bus.out_ready);
    assign accept_c   = bus.in_valid && in_ready_c;

    always_comb begin
        out_valid_d   = out_valid_q;
        op_d          = op_q;
        rd_d          = rd_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        imm_d         = imm_q;
        pc_d          = pc_q;
        illegal_d     = illegal_q;
        illegal_cnt_d = illegal_cnt_q;

        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept_c) begin
            out_valid_d = 1'b1;
            op_d        = dec_c.op;
            rd_d        = dec_c.rd;
            rs1_d       = dec_c.rs1;
            rs2_d       = dec_c.rs2;
            imm_d       = imm_c;
            pc_d        = bus.in_pc;
            illegal_d   = dec_c.illegal;
            if (dec_c.illegal && (illegal_cnt_q != '1)) begin
                illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            op_q          <= OP_NOP;
            rd_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            imm_q         <= '0;
            pc_q          <= '0;
            illegal_q     <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            imm_q         <= imm_d;
            pc_q          <= pc_d;
            illegal_q     <= illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_op      = op_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_rs1     = rs1_q;
    assign bus.out_rs2     = rs2_q;
    assign bus.out_imm     = imm_q;
    assign bus.out_pc      = pc_q;
    assign bus.out_illegal = illegal_q;
    assign bus.illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; three instances share one stimulus
// (default, zero-extending immediates, 2-bit illegal counter).
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'h0;
    logic [31:0] in_pc = 32'h0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [83:0] got;
    logic [83:0] exp;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32), .CNT_W(16)) bus_a ();
    decode_stage_if #(.XLEN(32), .CNT_W(16)) bus_z ();
    decode_stage_if #(.XLEN(32), .CNT_W(2))  bus_c ();

    assign bus_a.in_valid = in_valid;  assign bus_z.in_valid = in_valid;  assign bus_c.in_valid = in_valid;
    assign bus_a.in_instr = in_instr;  assign bus_z.in_instr = in_instr;  assign bus_c.in_instr = in_instr;
    assign bus_a.in_pc = in_pc;        assign bus_z.in_pc = in_pc;        assign bus_c.in_pc = in_pc;
    assign bus_a.flush = flush;        assign bus_z.flush = flush;        assign bus_c.flush = flush;
    assign bus_a.out_ready = out_ready; assign bus_z.out_ready = out_ready; assign bus_c.out_ready = out_ready;

    decode_stage #(.XLEN(32), .SIGN_EXT(1'b1), .CNT_W(16)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    decode_stage #(.XLEN(32), .SIGN_EXT(1'b0), .CNT_W(16)) u_dut_z (.clk(clk), .rst(rst), .bus(bus_z));
    decode_stage #(.XLEN(32), .SIGN_EXT(1'b1), .CNT_W(2))  u_dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    function automatic logic [83:0] bundle_a();
        return {4'(bus_a.out_op), bus_a.out_rd, bus_a.out_rs1, bus_a.out_rs2,
                bus_a.out_imm, bus_a.out_pc, bus_a.out_illegal};
    endfunction

    function automatic logic [83:0] mk(input logic [3:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [31:0] imm, input logic [31:0] pc,
                                       input logic ill);
        return {op, rd, rs1, rs2, imm, pc, ill};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'hFFFF_FFFF, 32'h0);
        step();
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (bus_a.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", bus_a.out_valid);
        end
        checks++; got = bundle_a(); exp = mk(4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        if (got !== exp) begin
            errors++; $display("FAIL reset_bundle: got %h expected %h", got, exp);
        end
        checks++;
        if (bus_a.illegal_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d expected 0", bus_a.illegal_cnt);
        end
        checks++;
        if (bus_a.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", bus_a.in_ready);
        end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(1'b1, 32'h0020_81B3, 32'h100);
        step();
        in_valid = 1'b0;
        checks++; got = bundle_a(); exp = mk(4'd1, 5'd3, 5'd1, 5'd2, 32'h0, 32'h100, 1'b0);
        if (bus_a.out_valid !== 1'b1 || got !== exp) begin
            errors++; $display("FAIL add: valid=%b got %h expected valid=1 %h", bus_a.out_valid, got, exp);
        end
        step();
        checks++;
        if (bus_a.out_valid !== 1'b0) begin
            errors++; $display("FAIL add_drain: got valid=%b expected 0", bus_a.out_valid);
        end
    endtask

    task automatic test_imm();
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF0_0093, 32'h104);
        step();
        drive(1'b1, 32'hFE51_2E23, 32'h108);
        checks++; got = bundle_a(); exp = mk(4'd5, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h104, 1'b0);
        if (bus_a.out_valid !== 1'b1 || got !== exp) begin
            errors++; $display("FAIL addi: got %h expected %h", got, exp);
        end
        checks++;
        if (bus_z.out_imm !== 32'h0000_0FFF) begin
            errors++; $display("FAIL addi_zext: got %h expected 00000fff", bus_z.out_imm);
        end
        step();
        drive(1'b1, 32'hFE20_8CE3, 32'h10C);
        checks++; got = bundle_a(); exp = mk(4'd4, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC, 32'h108, 1'b0);
        if (bus_a.out_valid !== 1'b1 || got !== exp) begin
            errors++; $display("FAIL sw: got %h expected %h", got, exp);
        end
        checks++;
        if (bus_z.out_imm !== 32'h0000_0FFC) begin
            errors++; $display("FAIL sw_zext: got %h expected 00000ffc", bus_z.out_imm);
        end
        step();
        drive(1'b1, 32'hFFDF_F0EF, 32'h110);
        checks++; got = bundle_a(); exp = mk(4'd7, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'h10C, 1'b0);
        if (bus_a.out_valid !== 1'b1 || got !== exp) begin
            errors++; $display("FAIL beq: got %h expected %h", got, exp);
        end
        checks++;
        if (bus_z.out_imm !== 32'h0000_1FF8) begin
            errors++; $display("FAIL beq_zext: got %h expected 00001ff8", bus_z.out_imm);
        end
        step();
        in_valid = 1'b0;
        checks++; got = bundle_a(); exp = mk(4'd8, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'h110, 1'b0);
        if (bus_a.out_valid !== 1'b1 || got !== exp) begin
            errors++; $display("FAIL jal: got %h expected %h", got, exp);
        end
        checks++;
        if (bus_z.out_imm !== 32'h001F_FFFC) begin
            errors++; $display("FAIL jal_zext: got %h expected 001ffffc", bus_z.out_imm);
        end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(1'b1, 32'h1234_50B7, 32'h120);
        step();
        drive(1'b1, 32'h0081_2283, 32'h124);
        #1;
        checks++; got = bundle_a(); exp = mk(4'd6, 5'd1, 5'd0, 5'd0, 32'h1234_5000, 32'h120, 1'b0);
        if (bus_a.out_valid !== 1'b1 || bus_a.in_ready !== 1'b1 || got !== exp) begin
            errors++; $display("FAIL lui: valid=%b ready=%b got %h expected %h",
                               bus_a.out_valid, bus_a.in_ready, got, exp);
        end
        step();
        in_valid = 1'b0;
        checks++; got = bundle_a(); exp = mk(4'd3, 5'd5, 5'd2, 5'd0, 32'h8, 32'h124, 1'b0);
        if (bus_a.out_valid !== 1'b1 || got !== exp) begin
            errors++; $display("FAIL lw_no_bubble: valid=%b got %h expected %h", bus_a.out_valid, got, exp);
        end
        step();
        checks++;
        if (bus_a.out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: got valid=%b expected 0", bus_a.out_valid);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        drive(1'b1, 32'h0020_81B3, 32'h200);
        step();
        drive(1'b1, 32'h0081_2283, 32'h204);
        exp = mk(4'd1, 5'd3, 5'd1, 5'd2, 32'h0, 32'h200, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; got = bundle_a();
            if (bus_a.in_ready !== 1'b0 || bus_a.out_valid !== 1'b1 || got !== exp) begin
                errors++; $display("FAIL stall_hold[%0d]: ready=%b valid=%b got %h expected ready=0 valid=1 %h",
                                   i, bus_a.in_ready, bus_a.out_valid, got, exp);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; got = bundle_a();
        if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b1 || got !== exp) begin
            errors++; $display("FAIL stall_release: ready=%b valid=%b got %h expected ready=1 valid=1 %h",
                               bus_a.in_ready, bus_a.out_valid, got, exp);
        end
        step();
        in_valid = 1'b0;
        checks++; got = bundle_a(); exp = mk(4'd3, 5'd5, 5'd2, 5'd0, 32'h8, 32'h204, 1'b0);
        if (bus_a.out_valid !== 1'b1 || got !== exp) begin
            errors++; $display("FAIL stall_next: valid=%b got %h expected %h", bus_a.out_valid, got, exp);
        end
        step();
        checks++;
        if (bus_a.out_valid !== 1'b0) begin
            errors++; $display("FAIL stall_no_dup: got valid=%b expected 0", bus_a.out_valid);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b0;
        drive(1'b1, 32'hFFFF_FFFF, 32'h300);
        step();
        flush = 1'b1;
        #1;
        checks++;
        if (bus_a.in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_in_ready: got %b expected 0", bus_a.in_ready);
        end
        checks++; got = bundle_a(); exp = mk(4'd15, 5'd0, 5'd0, 5'd0, 32'h0, 32'h300, 1'b1);
        if (bus_a.out_valid !== 1'b1 || got !== exp) begin
            errors++; $display("FAIL ill_bundle: valid=%b got %h expected %h", bus_a.out_valid, got, exp);
        end
        checks++;
        if (bus_a.illegal_cnt !== 16'd1 || bus_c.illegal_cnt !== 2'd1) begin
            errors++; $display("FAIL ill_cnt1: got %0d/%0d expected 1/1", bus_a.illegal_cnt, bus_c.illegal_cnt);
        end
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.illegal_cnt !== 16'd1) begin
            errors++; $display("FAIL flush_drop: valid=%b cnt=%0d expected valid=0 cnt=1",
                               bus_a.out_valid, bus_a.illegal_cnt);
        end
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            drive(1'b1, 32'hFFFF_FFFF, 32'h300 + 32'(4 * k));
            step();
            checks++;
            if (bus_a.out_valid !== 1'b1 || bus_a.illegal_cnt !== 16'(k)
                || bus_c.illegal_cnt !== 2'((k > 3) ? 3 : k)) begin
                errors++; $display("FAIL ill_sat[%0d]: valid=%b cnt=%0d cnt2=%0d expected valid=1 cnt=%0d cnt2=%0d",
                                   k, bus_a.out_valid, bus_a.illegal_cnt, bus_c.illegal_cnt,
                                   k, (k > 3) ? 3 : k);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_stall();
        out_ready = 1'b0;
        drive(1'b1, 32'h0020_81B3, 32'h400);
        step();
        checks++;
        if (bus_a.out_valid !== 1'b1) begin
            errors++; $display("FAIL rst_stall_pre: got valid=%b expected 1", bus_a.out_valid);
        end
        rst = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'hFFFF_FFFF, 32'h404);
        step();
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_stall: valid=%b ready=%b expected valid=0 ready=1",
                               bus_a.out_valid, bus_a.in_ready);
        end
        checks++;
        if (bus_a.illegal_cnt !== 16'd0 || bus_c.illegal_cnt !== 2'd0) begin
            errors++; $display("FAIL rst_stall_cnt: got %0d/%0d expected 0/0", bus_a.illegal_cnt, bus_c.illegal_cnt);
        end
        checks++; got = bundle_a(); exp = mk(4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        if (got !== exp) begin
            errors++; $display("FAIL rst_stall_bundle: got %h expected %h", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_reset_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
